// File: rtl/pkfb_packet_feeder.sv
// Fabric-side packet source for the ASSP packet FIFO: stream FIFO, packet framing, overflow drop.
// Optional PKFB_TIMESTAMP_EN prefixes every packet with a {8'h00, TimeStamp} header word.
module pkfb_packet_feeder #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned PKT_MAX    = 16,
    parameter int unsigned PUSH_CH    = 0
) (
    input  logic        Sys_PKfb_Clk,
    input  logic        Sys_PKfb_Rst_n,
    input  logic        Enable,
    input  logic [31:0] S_Data,
    input  logic        S_Valid,
    input  logic        S_Last,
    output logic        S_Ready,
    input  logic [23:0] TimeStamp,
    output logic [31:0] FB_PKfbData,
    output logic [3:0]  FB_PKfbPush,
    output logic        FB_PKfbSOF,
    output logic        FB_PKfbEOF,
    input  logic        FB_PKfbOverflow,
    input  logic        Stat_Clr,
    output logic        Ovf_Sticky,
    output logic [15:0] Drop_Cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] PUSH_MASK = 4'(1 << PUSH_CH);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

    logic [32:0] mem_q [DEPTH];
    ptr_t        wr_ptr_q, rd_ptr_q;
    cnt_t        count_q, count_d, avail_q, avail_d;
    logic        wr_seen_q, ready_q, ready_d;
    logic        wr_en, pop, avail;
    logic [31:0] head_data;
    logic        head_last;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_next;
    logic [31:0] data_q, data_d;
    logic        push_q, push_d, sof_q, sof_d, eof_q, eof_d;
    logic        pkt_end, drop_inc, ovf_ev;
    logic [15:0] drop_q, drop_d;
    logic        sticky_q, sticky_d;

    assign wr_en     = S_Valid && ready_q;
    assign avail     = (avail_q != '0);
    assign head_data = mem_q[rd_ptr_q][31:0];
    assign head_last = mem_q[rd_ptr_q][32];
    assign cnt_next  = cnt_q + 16'd1;
    assign ovf_ev    = FB_PKfbOverflow && push_q;

    always_ff @(posedge Sys_PKfb_Clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {S_Last, S_Data};
        end
    end

    // avail_q trails count_q by one write so a new word is popped no earlier than two edges after entry.
    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + cnt_t'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - cnt_t'(1);
        end
        avail_d = avail_q;
        if (wr_seen_q && !pop) begin
            avail_d = avail_q + cnt_t'(1);
        end else if (!wr_seen_q && pop) begin
            avail_d = avail_q - cnt_t'(1);
        end
        ready_d = (count_d != cnt_t'(DEPTH));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        push_d   = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        pop      = 1'b0;
        pkt_end  = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable && avail) begin
`ifdef PKFB_TIMESTAMP_EN
                    push_d  = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = {8'h00, TimeStamp};
                    cnt_d   = '0;
                    state_d = SEND;
`else
                    pop     = 1'b1;
                    push_d  = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = head_data;
                    cnt_d   = 16'd1;
                    pkt_end = head_last || (PKT_MAX == 1);
                    eof_d   = pkt_end;
                    state_d = pkt_end ? IDLE : SEND;
`endif
                end
            end
            SEND: begin
                if (avail) begin
                    pop     = 1'b1;
                    push_d  = 1'b1;
                    data_d  = head_data;
                    cnt_d   = cnt_next;
                    pkt_end = head_last || (cnt_next == 16'(PKT_MAX));
                    eof_d   = pkt_end;
                    if (pkt_end) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (avail) begin
                    pop     = 1'b1;
                    cnt_d   = cnt_next;
                    pkt_end = head_last || (cnt_next == 16'(PKT_MAX));
                    if (pkt_end) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Overflow on a non-final word: the word popped this cycle is discarded and may itself close the packet.
        if (ovf_ev && !eof_q) begin
            push_d = 1'b0;
            sof_d  = 1'b0;
            eof_d  = 1'b0;
            data_d = data_q;
            if (pop && pkt_end) begin
                drop_inc = 1'b1;
                state_d  = IDLE;
            end else begin
                state_d = DROP;
            end
        end else if (ovf_ev) begin
            drop_inc = 1'b1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_inc) begin
            if (Stat_Clr) begin
                drop_d = 16'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (Stat_Clr) begin
            drop_d = '0;
        end
        sticky_d = sticky_q;
        if (ovf_ev) begin
            sticky_d = 1'b1;
        end else if (Stat_Clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
        if (!Sys_PKfb_Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            avail_q   <= '0;
            wr_seen_q <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            push_q    <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            drop_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            count_q   <= count_d;
            avail_q   <= avail_d;
            wr_seen_q <= wr_en;
            ready_q   <= ready_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            push_q    <= push_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            drop_q    <= drop_d;
            sticky_q  <= sticky_d;
        end
    end

`ifndef PKFB_TIMESTAMP_EN
    logic unused_ts;
    assign unused_ts = ^TimeStamp;
`endif

    assign S_Ready     = ready_q;
    assign FB_PKfbData = data_q;
    assign FB_PKfbPush = push_q ? PUSH_MASK : 4'b0000;
    assign FB_PKfbSOF  = sof_q;
    assign FB_PKfbEOF  = eof_q;
    assign Ovf_Sticky  = sticky_q;
    assign Drop_Cnt    = drop_q;

endmodule

// File: tb/tb_pkfb_packet_feeder.sv
// Bench for pkfb_packet_feeder: packet-level expected-push model plus directed literal checks.
// Build with +define+PKFB_TIMESTAMP_EN to exercise the header-word variant.
module tb_pkfb_packet_feeder;

    localparam int unsigned PKT_MAX = 16;
    localparam int unsigned PUSH_CH = 0;
    localparam logic [3:0]  PMASK   = 4'b0001;
`ifdef PKFB_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Enable, S_Valid, S_Last, S_Ready, Stat_Clr;
    logic [31:0] S_Data, FB_PKfbData;
    logic [23:0] TimeStamp;
    logic [3:0]  FB_PKfbPush;
    logic        FB_PKfbSOF, FB_PKfbEOF, FB_PKfbOverflow, Ovf_Sticky;
    logic [15:0] Drop_Cnt;

    logic        ovf_en;
    logic [31:0] ovf_data;
    assign FB_PKfbOverflow = ovf_en && FB_PKfbPush[PUSH_CH] && (FB_PKfbData == ovf_data);

    always #5 clk = ~clk;

    pkfb_packet_feeder #(.DEPTH_LOG2(3), .PKT_MAX(PKT_MAX), .PUSH_CH(PUSH_CH)) dut (
        .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst_n(rst_n), .Enable(Enable),
        .S_Data(S_Data), .S_Valid(S_Valid), .S_Last(S_Last), .S_Ready(S_Ready),
        .TimeStamp(TimeStamp), .FB_PKfbData(FB_PKfbData), .FB_PKfbPush(FB_PKfbPush),
        .FB_PKfbSOF(FB_PKfbSOF), .FB_PKfbEOF(FB_PKfbEOF), .FB_PKfbOverflow(FB_PKfbOverflow),
        .Stat_Clr(Stat_Clr), .Ovf_Sticky(Ovf_Sticky), .Drop_Cnt(Drop_Cnt)
    );

    typedef struct {
        logic [31:0] d;
        bit          sof;
        bit          eof;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned m_cnt;
    bit          m_dropping;
    logic [15:0] m_drop;
    bit          m_sticky;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] log_data[$];
    bit          log_sof[$];
    bit          log_eof[$];
    int          log_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Packet model: every accepted word yields its expected push(es) from the framing rules.
    task automatic model_accept(input logic [31:0] d, input logic l);
        exp_t e;
        bit   last_of_pkt;
        if (m_cnt == 0 && TS) begin
            e.d = {8'h00, TimeStamp}; e.sof = 1'b1; e.eof = 1'b0;
            exp_q.push_back(e);
        end
        m_cnt++;
        last_of_pkt = l || (m_cnt == PKT_MAX);
        e.d = d; e.sof = !TS && (m_cnt == 1); e.eof = last_of_pkt;
        if (!m_dropping) exp_q.push_back(e);
        if (last_of_pkt) begin
            m_cnt = 0;
            m_dropping = 1'b0;
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        bit   found;
        cyc++;
        if (rst_n) begin
            if (FB_PKfbPush[PUSH_CH]) begin
                check("push_bus", {28'h0, FB_PKfbPush}, {28'h0, PMASK});
                log_data.push_back(FB_PKfbData);
                log_sof.push_back(FB_PKfbSOF);
                log_eof.push_back(FB_PKfbEOF);
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_push", FB_PKfbData, 32'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("push_data", FB_PKfbData, e.d);
                    check("push_sof", {31'h0, FB_PKfbSOF}, {31'h0, e.sof});
                    check("push_eof", {31'h0, FB_PKfbEOF}, {31'h0, e.eof});
                end
                if (FB_PKfbOverflow) begin
                    m_sticky = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                    if (!FB_PKfbEOF) begin
                        found = 1'b0;
                        while (exp_q.size() > 0 && !found) begin
                            e = exp_q.pop_front();
                            found = e.eof;
                        end
                        if (!found) m_dropping = 1'b1;
                    end
                end
            end else begin
                check("idle_bus", {26'h0, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int unsigned w = 0;
        S_Data = d; S_Last = l; S_Valid = 1'b1;
        while (!S_Ready && w < 200) begin
            tick();
            w++;
        end
        if (!S_Ready) begin
            check("send_timeout", {31'h0, S_Ready}, 32'h1);
        end else begin
            model_accept(d, l);
            tick();
        end
        S_Valid = 1'b0;
        S_Last = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        check(name, exp_q.size(), 32'h0);
        repeat (6) tick();
    endtask

    task automatic clear_log();
        log_data.delete(); log_sof.delete(); log_eof.delete(); log_cyc.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 0; m_dropping = 1'b0; m_drop = '0; m_sticky = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; Enable = 1'b1; S_Valid = 1'b0; S_Last = 1'b0; S_Data = '0;
        Stat_Clr = 1'b0; TimeStamp = 24'h123456; ovf_en = 1'b0; ovf_data = '0;
        model_reset();
        #12;
        check("rst_outputs", {FB_PKfbData[3:0], FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, S_Ready, Ovf_Sticky}, 32'h0);
        check("rst_drop", {16'h0, Drop_Cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'h0, S_Ready}, 32'h1);

        // Single-word packet: push lands two edges after acceptance.
        clear_log();
        send(32'hA5A5_0001, 1'b1);
        check("lat_n0", {28'h0, FB_PKfbPush}, 32'h0);
        tick();
        check("lat_n1", {28'h0, FB_PKfbPush}, 32'h0);
        tick();
        check("lat_n2_push", {28'h0, FB_PKfbPush}, 32'h1);
        check("lat_n2_data", FB_PKfbData, TS ? 32'h0012_3456 : 32'hA5A5_0001);
        check("lat_n2_sof", {31'h0, FB_PKfbSOF}, 32'h1);
        check("lat_n2_eof", {31'h0, FB_PKfbEOF}, TS ? 32'h0 : 32'h1);
        drain("drain_single");

        // 20 contiguous words, forced split at PKT_MAX.
        clear_log();
        for (int i = 0; i < 20; i++) send(32'h0100_0001 + i, 1'b0);
        drain("drain_split");
        check("split_npush", log_data.size(), TS ? 32'd22 : 32'd20);
`ifndef PKFB_TIMESTAMP_EN
        check("split_eof16", {31'h0, log_eof[15]}, 32'h1);
        check("split_sof17", {31'h0, log_sof[16]}, 32'h1);
        check("split_data17", log_data[16], 32'h0100_0011);
        check("split_contig", log_cyc[19] - log_cyc[0], 32'd19);
`endif
        send(32'h0100_0015, 1'b1);
        drain("drain_close");

        // Fill the FIFO with Enable low, then release it.
        clear_log();
        Enable = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h0200_0001 + i, i == 7);
        check("full_ready", {31'h0, S_Ready}, 32'h0);
        Enable = 1'b1;
`ifdef PKFB_TIMESTAMP_EN
        tick();
`endif
        tick();
        check("ready_back", {31'h0, S_Ready}, 32'h1);
        drain("drain_fill");
        check("fill_npush", log_data.size(), TS ? 32'd9 : 32'd8);

        // Overflow on word 3 of a 6-word packet, then a normal packet.
        clear_log();
        ovf_en = 1'b1; ovf_data = 32'h0300_0003;
        for (int i = 0; i < 6; i++) send(32'h0300_0001 + i, i == 5);
        send(32'h0400_0001, 1'b0);
        send(32'h0400_0002, 1'b1);
        drain("drain_ovf");
        ovf_en = 1'b0;
        check("ovf_npush", log_data.size(), TS ? 32'd7 : 32'd5);
        check("ovf_next_sof", {31'h0, log_sof[TS ? 4 : 3]}, 32'h1);
        check("drop_model", {16'h0, Drop_Cnt}, {16'h0, m_drop});
        check("drop_lit", {16'h0, Drop_Cnt}, 32'h1);
        check("sticky", {31'h0, Ovf_Sticky}, {31'h0, m_sticky});
        Stat_Clr = 1'b1;
        tick();
        Stat_Clr = 1'b0;
        m_drop = '0; m_sticky = 1'b0;
        check("clr_drop", {16'h0, Drop_Cnt}, 32'h0);
        check("clr_sticky", {31'h0, Ovf_Sticky}, 32'h0);

        // Reset mid-packet.
        for (int i = 0; i < 5; i++) send(32'h0500_0001 + i, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst", {FB_PKfbData[7:0], FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, S_Ready, Ovf_Sticky}, 32'h0);
        check("async_rst_data", FB_PKfbData, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("ready_rel", {31'h0, S_Ready}, 32'h1);
        clear_log();
        send(32'h0600_0001, 1'b0);
        send(32'h0600_0002, 1'b1);
        drain("drain_rst");
        check("rst_next_sof", {31'h0, log_sof[0]}, 32'h1);

        // Two-word packet: header variant gives three pushes.
        clear_log();
        send(32'hB000_0001, 1'b0);
        send(32'hB000_0002, 1'b1);
        drain("drain_two");
        check("two_npush", log_data.size(), TS ? 32'd3 : 32'd2);
        check("two_first", log_data[0], TS ? 32'h0012_3456 : 32'hB000_0001);
        check("two_eof", {31'h0, log_eof[TS ? 2 : 1]}, 32'h1);
        check("two_sof1", {31'h0, log_sof[1]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pkfb_packet_feeder.md
Name: pkfb_packet_feeder

Overview:
- Fabric-side packet source for the ASSP packet-FIFO interface.
- Accepts a 32-bit valid/ready word stream, buffers it in a small FIFO, frames it into packets and drives FB_PKfbData/FB_PKfbPush/FB_PKfbSOF/FB_PKfbEOF into the ASSP.
- Watches FB_PKfbOverflow and discards the rest of any packet that overflowed. Keeps drop statistics for a Wishbone-visible status register.

Parameters:
- DEPTH_LOG2, 3: log2 of internal FIFO depth (8 entries, each 32 data bits + 1 last bit).
- PKT_MAX, 16: maximum data words per packet; a forced EOF is emitted on word PKT_MAX. Legal range 1..65535.
- PUSH_CH, 0: index (0..3) of the FB_PKfbPush bit driven; all other push bits are held at 0.

Ports:
- Sys_PKfb_Clk  in  1  sole clock; same clock as the ASSP packet-FIFO push side.
- Sys_PKfb_Rst_n  in  1  asynchronous active-low reset.
- Enable  in  1  when low, no new packet starts; a packet in progress completes.
- S_Data  in  32  stream data.
- S_Valid  in  1  stream word valid.
- S_Last  in  1  marks the final word of an upstream packet.
- S_Ready  out  1  FIFO not full.
- TimeStamp  in  24  ASSP timestamp; used only with the optional feature.
- FB_PKfbData  out  32  packet word to the ASSP.
- FB_PKfbPush  out  4  one-hot push; only bit PUSH_CH is ever set.
- FB_PKfbSOF  out  1  first word of packet.
- FB_PKfbEOF  out  1  last word of packet.
- FB_PKfbOverflow  in  1  ASSP overflow; valid in the same cycle as the push it refers to.
- Stat_Clr  in  1  synchronous clear of statistics.
- Ovf_Sticky  out  1  set on any overflow.
- Drop_Cnt  out  16  number of packets truncated because of overflow; saturating.

Behaviour:
- Reset: all outputs 0, FIFO empty, word counter 0, state IDLE. Reset asserted mid-packet loses the partial packet; no EOF is emitted.
- FIFO:
  - Write when S_Valid && S_Ready. S_Ready = !full; it is registered from the FIFO count, so there is no combinational path from S_Valid to S_Ready.
  - Simultaneous read and write while full is not allowed, because S_Ready is low. Simultaneous read and write while empty is allowed; the word is written first and read on a later cycle.
- Outputs:
  - All FB_* outputs are registered. Each push is a single-cycle pulse carrying FB_PKfbData/SOF/EOF in that same cycle.
  - At most one word is pushed per cycle; back-to-back pushes are allowed.
  - Latency: a word accepted at edge N into an empty FIFO with Enable high is pushed at edge N+2.
- State machine, states IDLE / SEND / DROP:
  - IDLE: if Enable && !empty, pop and push a word with SOF=1 and count=1, then go to SEND. If that word also ends the packet (S_Last, or PKT_MAX==1), EOF=1 in the same cycle and the state stays IDLE.
  - SEND: pop and push when !empty; a gap cycle when empty has no push. EOF=1 when the popped word has last=1 or count==PKT_MAX, then go to IDLE. When the split is forced (count==PKT_MAX), the next word starts a new packet with SOF.
  - Overflow: FB_PKfbOverflow high during a push sets Ovf_Sticky.
    - If that word had EOF: Drop_Cnt += 1 and next state is IDLE.
    - Otherwise: next state is DROP, overriding the SEND transition. Any word already popped in that cycle counts as discarded.
  - DROP: pop without pushing until a popped word has last=1 or count reaches PKT_MAX. Then Drop_Cnt += 1 and go to IDLE. Enable is ignored in DROP.
- Counter: 16-bit, reset to 0 on packet start; forced-EOF compare uses count==PKT_MAX.
- Statistics:
  - Drop_Cnt saturates at 16'hFFFF.
  - Stat_Clr zeroes Drop_Cnt and Ovf_Sticky. If an increment or set occurs in the same cycle as Stat_Clr, the result is 1 (event wins over clear).

Optional Feature:
- Macro PKFB_TIMESTAMP_EN.
- Defined:
  - Each packet is prefixed by a header word {8'h00, TimeStamp} with SOF=1. TimeStamp is sampled in the cycle the header is pushed.
  - The first data word follows with SOF=0. PKT_MAX counts data words only.
  - Header insertion does not pop the FIFO and requires the FIFO to be !empty. Overflow on the header word → DROP for the whole packet.
- Not defined: TimeStamp is ignored and the first data word carries SOF.

Test Plan:
- Single-word packet (S_Last=1, data 32'hA5A5_0001), Enable=1 → push at N+2 with SOF=1 and EOF=1 in the same cycle; FB_PKfbPush=4'b0001.
- 20 contiguous words with no S_Last, PKT_MAX=16 → EOF on word 16, SOF on word 17, 20 pushes in 20 consecutive cycles.
- Fill 8 words with Enable=0 → S_Ready=0 after the 8th write. Raise Enable → 8 pushes; S_Ready returns one cycle after the first pop.
- FB_PKfbOverflow=1 on word 3 of a 6-word packet → words 4–6 not pushed, Drop_Cnt=1, Ovf_Sticky=1. The next packet is pushed normally with SOF. Stat_Clr pulse → both 0.
- Reset asserted mid-packet → all outputs 0 asynchronously, S_Ready=1 after release; the next packet starts with SOF.
- PKFB_TIMESTAMP_EN with TimeStamp=24'h123456, 2-word packet → 3 pushes: 32'h0012_3456 with SOF, data word, data word with EOF.
